// File: rtl/tppe_stream.sv
// tppe_stream: streaming sparse spike x weight dot-product engine.
// Intersects a spike mask with a weight mask, issues one fibre-A read per
// match, and folds each returned spike word into TIMESTEPS saturating
// accumulators. The accumulators can be carried across tiles for K-splitting.
module tppe_stream #(
  parameter int BITMASK_WIDTH = 128,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int TIMESTEPS     = 4,
  parameter int ACC_WIDTH     = 12,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BITMASK_WIDTH-1:0]            in_bitmask_a,
  input  logic [BITMASK_WIDTH-1:0]            in_bitmask_b,
  input  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] in_weights_flat,
  input  logic [ADDR_WIDTH-1:0]               in_base_addr,
  input  logic                                in_acc_keep,
  output logic [ADDR_WIDTH-1:0]               fibre_a_addr,
  output logic                                fibre_a_read_en,
  input  logic [TIMESTEPS-1:0]                fibre_a_data,
  input  logic                                fibre_a_valid,
  output logic [TIMESTEPS*ACC_WIDTH-1:0]      result_flat,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic [$clog2(BITMASK_WIDTH):0]      result_count,
  output logic                                result_sat,
  output logic                                err_unexpected
);

  localparam int CW = $clog2(BITMASK_WIDTH) + 1;
  localparam int IW = $clog2(BITMASK_WIDTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  // Number of set bits in a mask.
  function automatic logic [CW-1:0] popcount(input logic [BITMASK_WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < BITMASK_WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Signed saturating add of a weight into an accumulator; MSB of the
  // result flags that the sum was clamped.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [WEIGHT_WIDTH-1:0] w);
    logic signed [SW-1:0] s;
    s = $signed({acc[ACC_WIDTH-1], acc}) +
        $signed({{(SW-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w});
    if (s[SW-1] != s[SW-2]) begin
      if (s[SW-1]) return {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
      else         return {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      return {1'b0, s[ACC_WIDTH-1:0]};
    end
  endfunction

  state_t                              r_state;
  logic                                r_in_ready, r_result_valid, r_read_en;
  logic [ADDR_WIDTH-1:0]               r_addr, r_base;
  logic [BITMASK_WIDTH-1:0]            r_mask_a, r_mask_b, r_match;
  logic [BITMASK_WIDTH*WEIGHT_WIDTH-1:0] r_weights;
  logic [CW-1:0]                       r_count;
  logic [TIMESTEPS*ACC_WIDTH-1:0]      r_acc;
  logic                                r_sat, r_err;
  logic [IW-1:0]                       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]                       r_wptr, r_rptr;
  logic [PW:0]                         r_fcnt;

  logic                                w_idle, w_accept, w_full, w_issue, w_pop, w_clamp;
  logic [BITMASK_WIDTH-1:0]            w_src_a, w_src_b, w_match, w_low, w_below;
  logic [CW-1:0]                       w_rank_a, w_rank_b;
  logic [ADDR_WIDTH-1:0]               w_base, w_issue_addr;
  logic [IW-1:0]                       w_head_idx;
  logic [WEIGHT_WIDTH-1:0]             w_weight;
  logic [TIMESTEPS*ACC_WIDTH-1:0]      w_acc_upd;

  // In IDLE the first read is issued straight from the offered tile so it
  // leaves on the accept edge; afterwards the latched copies drive the scan.
  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_accept     = in_valid & r_in_ready;
    w_src_a      = w_idle ? in_bitmask_a : r_mask_a;
    w_src_b      = w_idle ? in_bitmask_b : r_mask_b;
    w_match      = w_idle ? (in_bitmask_a & in_bitmask_b) : r_match;
    w_base       = w_idle ? in_base_addr : r_base;
    w_low        = w_match & (~w_match + BITMASK_WIDTH'(1));
    w_below      = w_low - BITMASK_WIDTH'(1);
    w_rank_a     = popcount(w_src_a & w_below);
    w_rank_b     = popcount(w_src_b & w_below);
    w_issue_addr = w_base + ADDR_WIDTH'(w_rank_a);
    w_full       = (r_fcnt == FULL_CNT);
    w_issue      = (w_accept | (r_state == S_SCAN)) & (|w_match) & ~w_full;
    w_pop        = fibre_a_valid & (r_fcnt != '0);
    w_head_idx   = r_fifo[r_rptr];
    w_weight     = r_weights[w_head_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Accumulator update for the returning spike word.
  always_comb begin
    logic [ACC_WIDTH:0] v;
    w_acc_upd = r_acc;
    w_clamp   = 1'b0;
    for (int t = 0; t < TIMESTEPS; t++) begin
      v = sat_add(r_acc[t*ACC_WIDTH +: ACC_WIDTH], w_weight);
      if (fibre_a_data[t]) begin
        w_acc_upd[t*ACC_WIDTH +: ACC_WIDTH] = v[ACC_WIDTH-1:0];
        w_clamp = w_clamp | v[ACC_WIDTH];
      end else begin
        w_acc_upd[t*ACC_WIDTH +: ACC_WIDTH] = r_acc[t*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Tile FSM: latch tile, walk matches, wait for returns, hold result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b1;
      r_result_valid <= 1'b0;
      r_read_en      <= 1'b0;
      r_addr         <= '0;
      r_base         <= '0;
      r_mask_a       <= '0;
      r_mask_b       <= '0;
      r_match        <= '0;
      r_weights      <= '0;
      r_count        <= '0;
    end else begin
      r_read_en <= w_issue;
      if (w_issue) r_addr <= w_issue_addr;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mask_a   <= in_bitmask_a;
            r_mask_b   <= in_bitmask_b;
            r_weights  <= in_weights_flat;
            r_base     <= in_base_addr;
            r_match    <= w_match & ~(w_issue ? w_low : '0);
            r_count    <= CW'(w_issue);
            r_in_ready <= 1'b0;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            r_match <= r_match & ~w_low;
            r_count <= r_count + CW'(1);
          end
          if (r_match == '0) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_fcnt == '0) begin
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
            r_in_ready     <= 1'b1;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_result_valid <= 1'b0;
          r_in_ready     <= 1'b1;
        end
      endcase
    end
  end

  // Pending FIFO of weight indices for reads still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_issue) begin
        r_fifo[r_wptr] <= IW'(w_rank_b);
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_issue, w_pop})
        2'b10:   r_fcnt <= r_fcnt + (PW+1)'(1);
        2'b01:   r_fcnt <= r_fcnt - (PW+1)'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Accumulators, saturation flag and sticky unexpected-return error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!in_acc_keep) r_acc <= '0;
        r_sat <= 1'b0;
      end else if (w_pop) begin
        r_acc <= w_acc_upd;
        r_sat <= r_sat | w_clamp;
      end
      if (fibre_a_valid && (r_fcnt == '0)) r_err <= 1'b1;
    end
  end

  assign in_ready        = r_in_ready;
  assign result_valid    = r_result_valid;
  assign fibre_a_read_en = r_read_en;
  assign fibre_a_addr    = r_addr;
  assign result_flat     = r_acc;
  assign result_count    = r_count;
  assign result_sat      = r_sat;
  assign err_unexpected  = r_err;

endmodule
